// File: rtl/uart_tx_multi.sv
// Multi-channel UART transmitter: CHANNELS independent TX lines sharing one data bus.
// Optional parity bit enabled by defining UART_TX_PARITY_EN (adds the parity_odd port).
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | line high, tx_ready high, waiting for tx_valid
// S_START | driving the start bit (0)
// S_DATA  | driving data bits LSB first from the shift register
// S_PARITY| driving the latched parity bit (parity build only)
// S_STOP  | driving STOP_BITS stop bits (1)
module uart_tx_multi #(
    parameter int CLOCK_RATE = 1000,
    parameter int BAUD_RATE  = 100,
    parameter int CHANNELS   = 3,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic [CHANNELS-1:0]  tx_valid,
    output logic [CHANNELS-1:0]  tx_ready,
    output logic [CHANNELS-1:0]  tx_pin
`ifdef UART_TX_PARITY_EN
    ,
    input  logic                 parity_odd
`endif
);

    localparam int DIVISOR = CLOCK_RATE / BAUD_RATE;
    // Guarded so a bad DIVISOR reaches the elaboration error below instead of a zero-width vector.
    localparam int CNT_W   = (DIVISOR >= 2) ? $clog2(DIVISOR) : 1;
    localparam int IDX_W   = 3;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIVISOR - 1);
    localparam logic [IDX_W-1:0] LAST_DATA  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP  = IDX_W'(STOP_BITS - 1);

    generate
        if (DIVISOR < 2) begin : g_bad_divisor
            $error("uart_tx_multi: CLOCK_RATE / BAUD_RATE must be at least 2");
        end
        if (CHANNELS < 1 || CHANNELS > 6) begin : g_bad_channels
            $error("uart_tx_multi: CHANNELS must be 1..6");
        end
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
            $error("uart_tx_multi: DATA_BITS must be 5..8");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_multi: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t                 state, state_nxt;
        logic [CNT_W-1:0]       cnt, cnt_nxt;
        logic [IDX_W-1:0]       idx, idx_nxt;
        logic [DATA_BITS-1:0]   shreg, shreg_nxt;
        logic                   pin, pin_nxt;
        logic                   bit_done;
`ifdef UART_TX_PARITY_EN
        logic                   par, par_nxt;
`endif

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state <= S_IDLE;
                cnt   <= '0;
                idx   <= '0;
                shreg <= '0;
                pin   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                par   <= 1'b0;
`endif
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                idx   <= idx_nxt;
                shreg <= shreg_nxt;
                pin   <= pin_nxt;
`ifdef UART_TX_PARITY_EN
                par   <= par_nxt;
`endif
            end
        end

        assign bit_done = (cnt == '0);

        // The line value is computed alongside the state so tx_pin is a flop, never decoded.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            idx_nxt   = idx;
            shreg_nxt = shreg;
            pin_nxt   = pin;
`ifdef UART_TX_PARITY_EN
            par_nxt   = par;
`endif
            case (state)
                S_IDLE: begin
                    pin_nxt = 1'b1;
                    if (tx_valid[i]) begin
                        state_nxt = S_START;
                        cnt_nxt   = CNT_RELOAD;
                        idx_nxt   = '0;
                        shreg_nxt = tx_data;
                        pin_nxt   = 1'b0;
`ifdef UART_TX_PARITY_EN
                        par_nxt   = (^tx_data) ^ parity_odd;
`endif
                    end
                end
                S_START: begin
                    if (bit_done) begin
                        state_nxt = S_DATA;
                        cnt_nxt   = CNT_RELOAD;
                        idx_nxt   = '0;
                        pin_nxt   = shreg[0];
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        cnt_nxt = CNT_RELOAD;
                        if (idx == LAST_DATA) begin
                            idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
                            state_nxt = S_PARITY;
                            pin_nxt   = par;
`else
                            state_nxt = S_STOP;
                            pin_nxt   = 1'b1;
`endif
                        end else begin
                            idx_nxt   = idx + IDX_W'(1);
                            shreg_nxt = {1'b0, shreg[DATA_BITS-1:1]};
                            pin_nxt   = shreg[1];
                        end
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_done) begin
                        state_nxt = S_STOP;
                        cnt_nxt   = CNT_RELOAD;
                        idx_nxt   = '0;
                        pin_nxt   = 1'b1;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    pin_nxt = 1'b1;
                    if (bit_done) begin
                        if (idx == LAST_STOP) begin
                            state_nxt = S_IDLE;
                            cnt_nxt   = '0;
                            idx_nxt   = '0;
                        end else begin
                            idx_nxt = idx + IDX_W'(1);
                            cnt_nxt = CNT_RELOAD;
                        end
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    pin_nxt   = 1'b1;
                end
            endcase
        end

        assign tx_ready[i] = (state == S_IDLE);
        assign tx_pin[i]   = pin;
    end

endmodule

// File: doc/uart_tx_multi.md
# uart_tx_multi

Parametrised multi-channel UART transmitter, the successor to the single-purpose fixed-pin transmitter in the tile top level. It drives `CHANNELS` independent TX lines from one shared data bus, with a valid/ready handshake per channel. Frame format (data width, stop bits, optional parity) and baud rate are set at elaboration. The tile top wraps it and maps `tx_pin` onto `io_out`.

## Interface
- `CLOCK_RATE`, 1000: clock frequency in Hz.
- `BAUD_RATE`, 100: line rate in bit/s. `DIVISOR = CLOCK_RATE / BAUD_RATE` (integer division). Must be ≥ 2; a smaller value is an elaboration error.
- `CHANNELS`, 3: number of TX lines, 1–6.
- `DATA_BITS`, 8: data bits per frame, 5–8.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `tx_data`  in  DATA_BITS  shared byte bus, sampled by a channel only on its own handshake.
- `tx_valid`  in  CHANNELS  per-channel request.
- `tx_ready`  out  CHANNELS  per-channel idle/accept flag.
- `tx_pin`  out  CHANNELS  serial outputs, idle high.
- `parity_odd`  in  1  parity sense (1 = odd); present only with `UART_TX_PARITY_EN`.

## Operation
- Each channel is an independent FSM with states IDLE, START, DATA, PARITY, STOP.
- Each channel has a private baud counter of width clog2(DIVISOR), so bit edges align to that channel's handshake. There is no shared tick.
- Handshake: channel i accepts when `tx_valid[i] & tx_ready[i]` at a rising edge. On acceptance it:
  - latches `tx_data` (and `parity_odd` when the macro is defined);
  - moves IDLE → START.
- `tx_ready[i]` is 1 exactly when channel i is in IDLE; it is decoded from state only.
- Frame sequence:
  - START: drives 0.
  - DATA: drives `DATA_BITS` bits, LSB first.
  - PARITY: drives the parity bit (macro only).
  - STOP: drives 1 for `STOP_BITS` bits.
  - Then returns to IDLE.
- Each bit lasts exactly DIVISOR cycles. The baud counter reloads at every bit boundary. The bit index counter counts 0..DATA_BITS-1 in DATA and 0..STOP_BITS-1 in STOP.
- Each `tx_pin` is a registered output, glitch-free.
- Asserting `tx_valid` while a channel is busy has no effect; it is neither queued nor latched.
- Simultaneous handshakes on several channels all latch the same `tx_data` value in the same cycle.
- Channels never interact apart from sharing `tx_data`.
- Reset (`reset` low) is asynchronous and takes effect mid-frame as well:
  - all FSMs go to IDLE;
  - all counters clear to 0;
  - `tx_pin` = all ones, `tx_ready` = all ones.
  - The frame in progress is abandoned, not completed.
  - After `reset` deasserts, the first handshake is possible at the next rising edge.

## Timing
- Handshake at edge t: `tx_pin` falls at edge t+1, `tx_ready` falls at edge t+1.
- Frame length F = (1 + DATA_BITS + P + STOP_BITS) × DIVISOR cycles, where P = 1 with parity, 0 without.
- `tx_ready` is high again at edge t+1+F; the line is in the stop state until then.
- Back-to-back frames: if `tx_valid` is high when `tx_ready` returns, the handshake occurs at edge t+1+F. The next start bit begins at edge t+2+F, giving exactly one cycle of extra idle-high between frames.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state and the `parity_odd` port exist.
  - Parity bit = XOR of the data bits, XOR `parity_odd`.
  - P = 1.
- `UART_TX_PARITY_EN` undefined:
  - no PARITY state and no `parity_odd` port;
  - P = 0; DATA goes directly to STOP.

## Test plan
Parameters for all tests: CLOCK_RATE=1000, BAUD_RATE=250 (DIVISOR=4), CHANNELS=3, DATA_BITS=8, STOP_BITS=1.
- Reset: drive `reset`=0 mid-clock-cycle → `tx_pin`=3'b111 and `tx_ready`=3'b111 immediately, with no clock edge needed.
- Single frame, `tx_data`=8'hA5 on channel 0, no parity → `tx_pin[0]` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles starting edge t+1. `tx_ready[0]` is low for 40 cycles. Channels 1 and 2 stay high.
- Held valid, `tx_data`=8'h00 then 8'hFF → second start bit begins exactly 41 cycles after the first. The second frame's data bits are all 1.
- Channels 0 and 2 handshake together with 8'h3C → identical waveforms on `tx_pin[0]` and `tx_pin[2]`. `tx_pin[1]` stays 1. `tx_valid[1]` pulsed mid-frame on an idle-then-busy channel is ignored while busy.
- Reset mid-frame: assert `reset`=0 at bit 4 of the frame → `tx_pin[0]`=1 and `tx_ready[0]`=1 at once. The next frame after release is complete and correct.
- Parity (macro defined), `tx_data`=8'h07:
  - `parity_odd`=0 → parity bit 1;
  - `parity_odd`=1 → parity bit 0;
  - in both cases F=44 cycles.
